pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the architectural PC and sequences instruction fetch for the single-issue CPU.
//  - Issues fetch requests to instruction memory and hands each returned word to decode with a valid/ready handshake.
//  - Applies branch redirects resolved by execute: B = ALUCtl 31, BL = ALUCtl 32.
//  - Produces the BL link write for r14.
//  - Sits between imem and decode; execute drives the br_* inputs.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  PC_STEP       32'd4          sequential PC increment, bytes
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  reset        in   1   synchronous, active-high reset
//  stall        in   1   inhibits launch of a new fetch; never aborts an outstanding one
//  imem_req     out  1   fetch request, level; held until imem_ack
//  imem_addr    out  32  fetch address; stable while imem_req=1
//  imem_ack     in   1   one-cycle fetch completion; imem_rdata valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  instr_valid  out  1   instr/instr_pc valid for decode
//  instr        out  32  held instruction word
//  instr_pc     out  32  address of instr
//  instr_ready  in   1   decode accepts; handshake completes when instr_valid & instr_ready
//  br_valid     in   1   execute presents a resolved control-flow op this cycle
//  ALUCtl_code  in   11  op code; only 31 (B) and 32 (BL) act, all others ignored
//  br_address   in   24  signed word offset from branch instruction
//  br_pc        in   32  address of the branch instruction
//  link_we      out  1   one-cycle r14 write strobe
//  link_data    out  32  r14 write value
//  pc           out  32  current PC, i.e. next address to fetch
// BEHAVIOUR
//  Reset
//  - Values: state=IDLE, pc=RESET_VECTOR; imem_req, instr_valid, link_we = 0; instr, instr_pc, link_data = 0.
//  - Reset mid-fetch drops the request; a late imem_ack after reset is ignored.
//  State machine
//  - IDLE -> FETCH when !stall.
//  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: latch instr=imem_rdata, instr_pc=pc, pc<=pc+PC_STEP, go to HOLD.
//  - HOLD: instr_valid=1; outputs stable until accepted. On instr_valid & instr_ready: go to FETCH if !stall, else IDLE.
//  - DRAIN: imem_req=1 at the old address. On imem_ack: discard data, go to IDLE.
//  Redirect
//  - Condition: br_valid & (ALUCtl_code==31 | ALUCtl_code==32).
//  - Target = br_pc + ({{6{br_address[23]}},br_address}<<2) + 8, modulo 2^32; wrap-around allowed, no error.
//  - pc<=target at the next edge in every state. Priority: reset > redirect > normal flow.
//  - FETCH, no ack this cycle: go to DRAIN (address not changed mid-transaction).
//  - FETCH, ack same cycle: data discarded, go to IDLE.
//  - HOLD: instruction killed (instr_valid=0 next cycle), instr_ready ignored, go to IDLE.
//  - IDLE: stay IDLE. DRAIN: stay DRAIN, pc overwritten; the last redirect wins.
//  - Latency: from HOLD or IDLE with stall=0, imem_addr=target exactly 2 cycles after redirect (N -> IDLE@N+1 -> FETCH@N+2).
//  - BL only: link_we=1 for one cycle at N+1, link_data=br_pc+4. B leaves link_we=0.
//  Other inputs
//  - br_valid with any other code: no effect.
//  - Stall high in FETCH/DRAIN/HOLD: no effect on that transaction.
// STRUCTURE
//  - cpu_pkg: ALUCTL_B=11'd31, ALUCTL_BL=11'd32, PC_STEP, 2-bit state encoding {IDLE,FETCH,HOLD,DRAIN}.
//  - One combinational sub-module: branch_target_calc (br_pc, br_address -> target, link).
//  - FSM, pc register and output registers stay in pc_sequencer.
// TESTING
//  - Reset, stall=0, imem acks 1 cycle after req -> addrs 0,4,8 fetched; instr_pc matches; link_we never 1.
//  - B: br_pc=0x100, br_address=24'h000010, while in HOLD -> instr_valid drops; imem_addr=0x148 two cycles later.
//  - BL: br_pc=0x200, br_address=24'hFFFFFE -> target 0x200; link_we pulse, link_data=0x204.
//  - Redirect in FETCH, ack 3 cycles later -> DRAIN holds old addr, data discarded, then fetch at target; never instr_valid for old data.
//  - Wrap: br_pc=0xFFFF_FFF0, br_address=24'h000004 -> target 0x0000_0008.
//  - stall=1 in HOLD with instr_ready=1 -> IDLE, imem_req=0 until stall=0; br_valid with code 5 -> pc unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: branch op codes, PC step and sequencer states.
// Latency: none (definitions only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam logic [10:0] ALUCTL_B  = 11'd31;
    localparam logic [10:0] ALUCTL_BL = 11'd32;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // IDLE: no fetch in flight; FETCH: request out; HOLD: word waiting for decode;
    // DRAIN: request out for a fetch whose data will be thrown away after a redirect.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Computes the branch target and the BL link value from the branch PC and word offset.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module branch_target_calc
    import cpu_pkg::*;
(
    input  logic [31:0] br_pc,
    input  logic [23:0] br_address,
    output logic [31:0] target,
    output logic [31:0] link
);

    logic [31:0] byte_offset;

    // Sign-extend the word offset and scale to bytes; the +8 accounts for the
    // pipeline-visible PC being two instructions ahead of the branch.
    assign byte_offset = {{6{br_address[23]}}, br_address, 2'b00};
    assign target      = br_pc + byte_offset + 32'd8;
    assign link        = br_pc + 32'd4;

endmodule

// File: rtl/pc_sequencer.sv
// Owns the PC, issues fetches to imem and hands fetched words to decode; applies B/BL redirects.
// Latency: word valid to decode the cycle after imem_ack; redirect target fetched 2 cycles after br_valid.
// Backpressure: decode holds the word via instr_ready; stall only blocks launching a new fetch.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = cpu_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        br_valid,
    input  logic [10:0] ALUCtl_code,
    input  logic [23:0] br_address,
    input  logic [31:0] br_pc,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic [31:0] pc
);

    seq_state_t  state;
    logic [31:0] br_target;
    logic [31:0] br_link;
    logic        is_bl;
    logic        redirect;

    branch_target_calc u_target (
        .br_pc      (br_pc),
        .br_address (br_address),
        .target     (br_target),
        .link       (br_link)
    );

    assign is_bl    = (ALUCtl_code == ALUCTL_BL);
    assign redirect = br_valid & ((ALUCtl_code == ALUCTL_B) | is_bl);

    // Sequencer FSM, PC and all registered outputs; reset beats redirect beats normal flow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_VECTOR;
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            instr_pc    <= 32'd0;
            link_we     <= 1'b0;
            link_data   <= 32'd0;
        end else begin
            link_we <= 1'b0;
            if (redirect) begin
                pc      <= br_target;
                link_we <= is_bl;
                if (is_bl) begin
                    link_data <= br_link;
                end
                case (state)
                    IDLE: state <= IDLE;
                    // An outstanding request cannot be withdrawn; keep the old
                    // address on the bus and drop the data when it arrives.
                    FETCH: begin
                        if (imem_ack) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                    HOLD: begin
                        state       <= IDLE;
                        instr_valid <= 1'b0;
                    end
                    DRAIN: begin
                        if (imem_ack) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (!stall) begin
                            state     <= FETCH;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end
                    end
                    FETCH: begin
                        if (imem_ack) begin
                            state       <= HOLD;
                            imem_req    <= 1'b0;
                            instr       <= imem_rdata;
                            instr_pc    <= imem_addr;
                            instr_valid <= 1'b1;
                            pc          <= pc + PC_STEP;
                        end
                    end
                    HOLD: begin
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                            if (!stall) begin
                                state     <= FETCH;
                                imem_req  <= 1'b1;
                                imem_addr <= pc;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    DRAIN: begin
                        if (imem_ack) begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        br_valid;
    logic [10:0] ALUCtl_code;
    logic [23:0] br_address;
    logic [31:0] br_pc;
    logic        link_we;
    logic [31:0] link_data;
    logic [31:0] pc;

    int tests  = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .br_valid    (br_valid),
        .ALUCtl_code (ALUCtl_code),
        .br_address  (br_address),
        .br_pc       (br_pc),
        .link_we     (link_we),
        .link_data   (link_data),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    // One clock of stimulus plus the outputs expected just after that edge.
    typedef struct {
        logic        stall;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        bv;
        logic [10:0] code;
        logic [23:0] ba;
        logic [31:0] bpc;
        logic        req;
        logic [31:0] addr;
        logic        ivld;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        lwe;
        logic [31:0] ldata;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(
        input logic stall_i, input logic ack_i, input logic [31:0] rdata_i, input logic rdy_i,
        input logic bv_i, input logic [10:0] code_i, input logic [23:0] ba_i, input logic [31:0] bpc_i,
        input logic req_i, input logic [31:0] addr_i, input logic ivld_i, input logic [31:0] instr_i,
        input logic [31:0] ipc_i, input logic lwe_i, input logic [31:0] ldata_i, input logic [31:0] pc_i);
        vec_t v;
        v.stall = stall_i; v.ack = ack_i; v.rdata = rdata_i; v.rdy = rdy_i;
        v.bv = bv_i; v.code = code_i; v.ba = ba_i; v.bpc = bpc_i;
        v.req = req_i; v.addr = addr_i; v.ivld = ivld_i; v.instr = instr_i;
        v.ipc = ipc_i; v.lwe = lwe_i; v.ldata = ldata_i; v.pc = pc_i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        chk({tag, " imem_req"},    {31'd0, imem_req},    {31'd0, v.req});
        chk({tag, " imem_addr"},   imem_addr,            v.addr);
        chk({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, v.ivld});
        chk({tag, " instr"},       instr,                v.instr);
        chk({tag, " instr_pc"},    instr_pc,             v.ipc);
        chk({tag, " link_we"},     {31'd0, link_we},     {31'd0, v.lwe});
        chk({tag, " link_data"},   link_data,            v.ldata);
        chk({tag, " pc"},          pc,                   v.pc);
    endtask

    // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
    task automatic step(input string tag, input logic rst, input vec_t v);
        reset       = rst;
        stall       = v.stall;
        imem_ack    = v.ack;
        imem_rdata  = v.rdata;
        instr_ready = v.rdy;
        br_valid    = v.bv;
        ALUCtl_code = v.code;
        br_address  = v.ba;
        br_pc       = v.bpc;
        @(posedge clk);
        #1;
        check_outputs(tag, v);
    endtask

    localparam logic [10:0] B  = 11'd31;
    localparam logic [10:0] BL = 11'd32;

    vec_t tbl[26];
    vec_t hs[15];

    initial begin
        // Columns: stall ack rdata rdy | bv code ba bpc || req addr ivld instr ipc lwe ldata pc
        // Sequential fetch 0,4,8 with a one-cycle ack delay.
        tbl[0]  = mk(0,0,32'h0,0,        0,0,24'h0,32'h0,      1,32'h000,0,32'h0,32'h000,0,32'h000,32'h000);
        tbl[1]  = mk(0,0,32'h0,0,        0,0,24'h0,32'h0,      1,32'h000,0,32'h0,32'h000,0,32'h000,32'h000);
        tbl[2]  = mk(0,1,32'hE0000001,0, 0,0,24'h0,32'h0,      0,32'h000,1,32'hE0000001,32'h000,0,32'h000,32'h004);
        tbl[3]  = mk(0,0,32'h0,1,        0,0,24'h0,32'h0,      1,32'h004,0,32'hE0000001,32'h000,0,32'h000,32'h004);
        tbl[4]  = mk(0,0,32'h0,0,        0,0,24'h0,32'h0,      1,32'h004,0,32'hE0000001,32'h000,0,32'h000,32'h004);
        tbl[5]  = mk(0,1,32'hE0000002,0, 0,0,24'h0,32'h0,      0,32'h004,1,32'hE0000002,32'h004,0,32'h000,32'h008);
        tbl[6]  = mk(0,0,32'h0,0,        0,0,24'h0,32'h0,      0,32'h004,1,32'hE0000002,32'h004,0,32'h000,32'h008);
        tbl[7]  = mk(0,0,32'h0,1,        0,0,24'h0,32'h0,      1,32'h008,0,32'hE0000002,32'h004,0,32'h000,32'h008);
        tbl[8]  = mk(0,0,32'h0,0,        0,0,24'h0,32'h0,      1,32'h008,0,32'hE0000002,32'h004,0,32'h000,32'h008);
        tbl[9]  = mk(0,1,32'hE0000003,0, 0,0,24'h0,32'h0,      0,32'h008,1,32'hE0000003,32'h008,0,32'h000,32'h00C);
        // B in HOLD (ready ignored): target 0x100 + 0x40 + 8 = 0x148, fetched two cycles later.
        tbl[10] = mk(0,0,32'h0,1,        1,B,24'h000010,32'h100, 0,32'h008,0,32'hE0000003,32'h008,0,32'h000,32'h148);
        tbl[11] = mk(0,0,32'h0,0,        0,0,24'h0,32'h0,      1,32'h148,0,32'hE0000003,32'h008,0,32'h000,32'h148);
        tbl[12] = mk(0,1,32'hE0000004,0, 0,0,24'h0,32'h0,      0,32'h148,1,32'hE0000004,32'h148,0,32'h000,32'h14C);
        // BL in HOLD: target 0x200 - 8 + 8 = 0x200, link 0x204 strobed for one cycle.
        tbl[13] = mk(0,0,32'h0,0,        1,BL,24'hFFFFFE,32'h200, 0,32'h148,0,32'hE0000004,32'h148,1,32'h204,32'h200);
        tbl[14] = mk(0,0,32'h0,0,        0,0,24'h0,32'h0,      1,32'h200,0,32'hE0000004,32'h148,0,32'h204,32'h200);
        tbl[15] = mk(0,1,32'hE0000005,0, 0,0,24'h0,32'h0,      0,32'h200,1,32'hE0000005,32'h200,0,32'h204,32'h204);
        tbl[16] = mk(0,0,32'h0,1,        0,0,24'h0,32'h0,      1,32'h204,0,32'hE0000005,32'h200,0,32'h204,32'h204);
        // br_valid with a non-branch code does nothing.
        tbl[17] = mk(0,0,32'h0,0,        1,11'd5,24'h000010,32'h100, 1,32'h204,0,32'hE0000005,32'h200,0,32'h204,32'h204);
        tbl[18] = mk(0,1,32'hE0000006,0, 0,0,24'h0,32'h0,      0,32'h204,1,32'hE0000006,32'h204,0,32'h204,32'h208);
        // Stall while accepting in HOLD parks in IDLE until stall drops.
        tbl[19] = mk(1,0,32'h0,1,        0,0,24'h0,32'h0,      0,32'h204,0,32'hE0000006,32'h204,0,32'h204,32'h208);
        tbl[20] = mk(1,0,32'h0,0,        0,0,24'h0,32'h0,      0,32'h204,0,32'hE0000006,32'h204,0,32'h204,32'h208);
        tbl[21] = mk(1,0,32'h0,0,        1,11'd5,24'h000040,32'h300, 0,32'h204,0,32'hE0000006,32'h204,0,32'h204,32'h208);
        tbl[22] = mk(0,0,32'h0,0,        0,0,24'h0,32'h0,      1,32'h208,0,32'hE0000006,32'h204,0,32'h204,32'h208);
        tbl[23] = mk(0,1,32'hE0000007,0, 0,0,24'h0,32'h0,      0,32'h208,1,32'hE0000007,32'h208,0,32'h204,32'h20C);
        // Stall in HOLD without ready has no effect on the held word.
        tbl[24] = mk(1,0,32'h0,0,        0,0,24'h0,32'h0,      0,32'h208,1,32'hE0000007,32'h208,0,32'h204,32'h20C);
        tbl[25] = mk(0,0,32'h0,1,        0,0,24'h0,32'h0,      1,32'h20C,0,32'hE0000007,32'h208,0,32'h204,32'h20C);

        // Redirect in FETCH with late ack: DRAIN keeps old address, second redirect wins.
        hs[0]  = mk(0,0,32'h0,0,         1,B,24'h000004,32'h300, 1,32'h20C,0,32'hE0000007,32'h208,0,32'h204,32'h318);
        hs[1]  = mk(0,0,32'h0,0,         0,0,24'h0,32'h0,      1,32'h20C,0,32'hE0000007,32'h208,0,32'h204,32'h318);
        hs[2]  = mk(1,0,32'h0,1,         0,0,24'h0,32'h0,      1,32'h20C,0,32'hE0000007,32'h208,0,32'h204,32'h318);
        hs[3]  = mk(0,0,32'h0,0,         1,BL,24'h000000,32'h400, 1,32'h20C,0,32'hE0000007,32'h208,1,32'h404,32'h408);
        hs[4]  = mk(0,1,32'hDEADBEEF,1,  0,0,24'h0,32'h0,      0,32'h20C,0,32'hE0000007,32'h208,0,32'h404,32'h408);
        hs[5]  = mk(0,0,32'h0,0,         0,0,24'h0,32'h0,      1,32'h408,0,32'hE0000007,32'h208,0,32'h404,32'h408);
        hs[6]  = mk(0,1,32'hE0000008,0,  0,0,24'h0,32'h0,      0,32'h408,1,32'hE0000008,32'h408,0,32'h404,32'h40C);
        hs[7]  = mk(0,0,32'h0,1,         0,0,24'h0,32'h0,      1,32'h40C,0,32'hE0000008,32'h408,0,32'h404,32'h40C);
        // Redirect in FETCH with ack in the same cycle: data dropped, straight to IDLE.
        hs[8]  = mk(0,1,32'hBADBAD00,0,  1,B,24'h000000,32'h500, 0,32'h40C,0,32'hE0000008,32'h408,0,32'h404,32'h508);
        hs[9]  = mk(0,0,32'h0,0,         0,0,24'h0,32'h0,      1,32'h508,0,32'hE0000008,32'h408,0,32'h404,32'h508);
        hs[10] = mk(0,1,32'hE0000009,0,  0,0,24'h0,32'h0,      0,32'h508,1,32'hE0000009,32'h508,0,32'h404,32'h50C);
        // Wrap: 0xFFFF_FFF0 + 0x10 + 8 = 0x0000_0008.
        hs[11] = mk(0,0,32'h0,0,         1,B,24'h000004,32'hFFFFFFF0, 0,32'h508,0,32'hE0000009,32'h508,0,32'h404,32'h008);
        hs[12] = mk(0,0,32'h0,0,         0,0,24'h0,32'h0,      1,32'h008,0,32'hE0000009,32'h508,0,32'h404,32'h008);
        // Reset mid-fetch, then a late ack while stalled in IDLE is ignored.
        hs[13] = mk(1,1,32'h11111111,0,  0,0,24'h0,32'h0,      0,32'h000,0,32'h0,32'h000,0,32'h000,32'h000);
        hs[14] = mk(0,0,32'h0,0,         0,0,24'h0,32'h0,      1,32'h000,0,32'h0,32'h000,0,32'h000,32'h000);

        // Reset state
        reset = 1'b1; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        br_valid = 1'b0; ALUCtl_code = '0; br_address = '0; br_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", mk(0,0,0,0,0,0,0,0, 0,32'h0,0,32'h0,32'h0,0,32'h0,32'h0));

        for (int i = 0; i < 26; i++) begin
            step($sformatf("tbl%0d", i), 1'b0, tbl[i]);
        end

        for (int i = 0; i < 13; i++) begin
            step($sformatf("seq%0d", i), 1'b0, hs[i]);
        end
        step("reset_mid_fetch", 1'b1, hs[13]);
        // Late ack arrives while stalled in IDLE after reset.
        step("late_ack", 1'b0, mk(1,1,32'h11111111,0, 0,0,24'h0,32'h0, 0,32'h000,0,32'h0,32'h000,0,32'h000,32'h000));
        step("post_reset_fetch", 1'b0, hs[14]);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
